// File: rtl/max_pooling_fprop1_pool2x2_stream.sv
// 2x2 stride-2 signed max pooling over a raster-order pixel stream, HLS start/done control.
// Optional MAX_POOL_RELU_EN clamps negative pooled results to zero.
module max_pooling_fprop1_pool2x2_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_W      = 64,
    parameter int DIM_WIDTH  = 8
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ap_start,
    output logic                         ap_done,
    output logic                         ap_idle,
    input  logic [DIM_WIDTH-1:0]         cfg_width,
    input  logic [DIM_WIDTH-1:0]         cfg_height,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int LB_DEPTH = MAX_W / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [DIM_WIDTH-1:0] ONE_DIM   = DIM_WIDTH'(1);
    localparam logic [DIM_WIDTH-1:0] MIN_DIM   = DIM_WIDTH'(2);
    localparam logic [DIM_WIDTH-1:0] MAX_W_DIM = DIM_WIDTH'(MAX_W);

    logic [1:0]                   state_q, state_d;
    logic [DIM_WIDTH-1:0]         width_q, width_d;
    logic [DIM_WIDTH-1:0]         height_q, height_d;
    logic [DIM_WIDTH-1:0]         col_q, col_d;
    logic [DIM_WIDTH-1:0]         row_q, row_d;
    logic signed [DATA_WIDTH-1:0] pair_q, pair_d;
    logic signed [DATA_WIDTH-1:0] outData_q, outData_d;
    logic                         outValid_q, outValid_d;
    logic signed [DATA_WIDTH-1:0] lbuf_q [LB_DEPTH];

    logic                         accept;
    logic                         lastCol;
    logic                         lastRow;
    logic                         lbufWe;
    logic [LB_AW-1:0]             lbufIdx;
    logic signed [DATA_WIDTH-1:0] pairMax;
    logic signed [DATA_WIDTH-1:0] windowMax;
    logic signed [DATA_WIDTH-1:0] pooled;

    function automatic logic signed [DATA_WIDTH-1:0] smax(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

    assign in_ready  = (state_q == RUN) && (!outValid_q || out_ready);
    assign accept    = in_ready && in_valid;
    assign ap_idle   = (state_q == IDLE);
    assign ap_done   = (state_q == DONE);
    assign out_data  = outData_q;
    assign out_valid = outValid_q;

    assign lastCol   = (col_q == width_q - ONE_DIM);
    assign lastRow   = (row_q == height_q - ONE_DIM);
    assign lbufIdx   = col_q[LB_AW:1];
    assign pairMax   = smax(pair_q, in_data);
    assign windowMax = smax(lbuf_q[lbufIdx], pairMax);
    // Odd-width last columns are even-indexed, so they only ever land in the pair register.
    assign lbufWe    = accept && col_q[0] && !row_q[0];

`ifdef MAX_POOL_RELU_EN
    assign pooled = windowMax[DATA_WIDTH-1] ? '0 : windowMax;
`else
    assign pooled = windowMax;
`endif

    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        height_d   = height_q;
        col_d      = col_q;
        row_d      = row_q;
        pair_d     = pair_q;
        outData_d  = outData_q;
        outValid_d = outValid_q;

        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    if (cfg_width < MIN_DIM)
                        width_d = MIN_DIM;
                    else if (cfg_width > MAX_W_DIM)
                        width_d = MAX_W_DIM;
                    else
                        width_d = cfg_width;
                    height_d = (cfg_height < MIN_DIM) ? MIN_DIM : cfg_height;
                    col_d    = '0;
                    row_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (lastCol) begin
                        col_d = '0;
                        row_d = row_q + ONE_DIM;
                        if (lastRow)
                            state_d = DRAIN;
                    end else begin
                        col_d = col_q + ONE_DIM;
                    end
                end
            end
            DRAIN: begin
                if (!outValid_q || out_ready)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (outValid_q && out_ready)
            outValid_d = 1'b0;

        if (accept && !col_q[0])
            pair_d = in_data;

        if (accept && col_q[0] && row_q[0]) begin
            outValid_d = 1'b1;
            outData_d  = pooled;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q    <= IDLE;
            width_q    <= '0;
            height_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            pair_q     <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            for (int i = 0; i < LB_DEPTH; i++)
                lbuf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            height_q   <= height_d;
            col_q      <= col_d;
            row_q      <= row_d;
            pair_q     <= pair_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            if (lbufWe)
                lbuf_q[lbufIdx] <= pairMax;
        end
    end

endmodule

// File: tb/tb_max_pooling_fprop1_pool2x2_stream.sv
// Scoreboard bench for the 2x2 max-pool stream: directed frames push expected results,
// a negedge monitor pops and compares each output transfer.
module tb_max_pooling_fprop1_pool2x2_stream;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic               ap_start;
    logic               ap_done;
    logic               ap_idle;
    logic [7:0]         cfg_width;
    logic [7:0]         cfg_height;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;

    int checkCount = 0;
    int passCount  = 0;
    int doneCount  = 0;
    int acceptCount = 0;
    logic signed [15:0] expQ [$];

    max_pooling_fprop1_pool2x2_stream #(
        .DATA_WIDTH(16),
        .MAX_W(64),
        .DIM_WIDTH(8)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .ap_start  (ap_start),
        .ap_done   (ap_done),
        .ap_idle   (ap_idle),
        .cfg_width (cfg_width),
        .cfg_height(cfg_height),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Output transfers complete at the next rising edge, so sampling valid&ready here sees each exactly once.
    always @(negedge ap_clk) begin
        if (ap_rst_n && ap_done)
            doneCount++;
        if (ap_rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0)
                checkOutput("unexpected_output", int'(out_data), -99999);
            else
                checkOutput("pooled_value", int'(out_data), int'(expQ.pop_front()));
        end
    end

    task automatic applyStimulus(input logic signed [15:0] value);
        bit got = 0;
        in_data  = value;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge ap_clk);
            if (in_ready)
                got = 1;
            @(posedge ap_clk);
            #1;
        end
        in_valid = 1'b0;
        if (got)
            acceptCount++;
        else
            checkOutput("input_accept_timeout", 0, 1);
    endtask

    task automatic startFrame(input logic [7:0] w, input logic [7:0] h);
        checkOutput("idle_before_start", int'(ap_idle), 1);
        cfg_width  = w;
        cfg_height = h;
        ap_start   = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start    = 1'b0;
        acceptCount = 0;
    endtask

    task automatic waitDone(input string name);
        bit seen = 0;
        for (int t = 0; t < 500 && !seen; t++) begin
            @(negedge ap_clk);
            if (ap_done)
                seen = 1;
        end
        checkOutput(name, int'(seen), 1);
        @(posedge ap_clk);
        #1;
        checkOutput("queue_drained", expQ.size(), 0);
    endtask

    initial begin
        logic signed [15:0] relu2;
        int doneBefore;

        ap_rst_n   = 1'b0;
        ap_start   = 1'b0;
        cfg_width  = 8'd0;
        cfg_height = 8'd0;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;

        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_data", int'(out_data), 0);
        checkOutput("reset_ap_idle", int'(ap_idle), 1);
        checkOutput("reset_ap_done", int'(ap_done), 0);
        checkOutput("reset_in_ready", int'(in_ready), 0);

        $display("[TB] test 1: 4x4 ramp");
        doneBefore = doneCount;
        expQ.push_back(16'sd5);
        expQ.push_back(16'sd7);
        expQ.push_back(16'sd13);
        expQ.push_back(16'sd15);
        startFrame(8'd4, 8'd4);
        for (int i = 0; i < 16; i++)
            applyStimulus(16'(i));
        waitDone("t1_done");
        repeat (3) @(posedge ap_clk);
        checkOutput("t1_done_pulses", doneCount - doneBefore, 1);

        $display("[TB] test 2: 2x2 negatives");
`ifdef MAX_POOL_RELU_EN
        relu2 = 16'sd0;
`else
        relu2 = -16'sd1;
`endif
        expQ.push_back(relu2);
        startFrame(8'd2, 8'd2);
        applyStimulus(-16'sd3);
        applyStimulus(-16'sd7);
        applyStimulus(-16'sd1);
        applyStimulus(-16'sd9);
        waitDone("t2_done");

        $display("[TB] test 3: 5x3 odd dimensions");
        expQ.push_back(16'sd7);
        expQ.push_back(16'sd9);
        startFrame(8'd5, 8'd3);
        for (int i = 1; i <= 15; i++)
            applyStimulus(16'(i));
        waitDone("t3_done");
        checkOutput("t3_inputs_accepted", acceptCount, 15);

        $display("[TB] test 4: 4x2 with output backpressure");
        expQ.push_back(16'sd6);
        expQ.push_back(16'sd8);
        out_ready = 1'b0;
        startFrame(8'd4, 8'd2);
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    applyStimulus(16'(i));
            end
            begin
                bit seen = 0;
                for (int t = 0; t < 200 && !seen; t++) begin
                    @(negedge ap_clk);
                    if (out_valid)
                        seen = 1;
                end
                checkOutput("t4_first_valid", int'(seen), 1);
                for (int c = 0; c < 6; c++) begin
                    checkOutput("t4_hold_data", int'(out_data), 6);
                    checkOutput("t4_hold_in_ready", int'(in_ready), 0);
                    @(posedge ap_clk);
                    #1;
                    if (c < 5)
                        @(negedge ap_clk);
                end
                out_ready = 1'b1;
            end
        join
        waitDone("t4_done");

        $display("[TB] test 5: reset mid-frame");
        startFrame(8'd4, 8'd4);
        for (int i = 0; i < 5; i++)
            applyStimulus(16'sd20 + 16'(i));
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        checkOutput("t5_out_valid", int'(out_valid), 0);
        checkOutput("t5_ap_idle", int'(ap_idle), 1);
        expQ.push_back(16'sd4);
        startFrame(8'd2, 8'd2);
        applyStimulus(16'sd1);
        applyStimulus(16'sd2);
        applyStimulus(16'sd3);
        applyStimulus(16'sd4);
        waitDone("t5_done");

        $display("[TB] test 6: signed extremes");
        expQ.push_back(16'sh7FFF);
        startFrame(8'd2, 8'd2);
        applyStimulus(16'sh7FFF);
        applyStimulus(16'sh8000);
        applyStimulus(16'sh8000);
        applyStimulus(16'sh8000);
        waitDone("t6_done");

        $display("[TB] test 7: equal values");
        expQ.push_back(-16'sd5);
`ifdef MAX_POOL_RELU_EN
        expQ[0] = 16'sd0;
`endif
        startFrame(8'd2, 8'd2);
        for (int i = 0; i < 4; i++)
            applyStimulus(-16'sd5);
        waitDone("t7_done");

        repeat (3) @(posedge ap_clk);
        checkOutput("final_idle", int'(ap_idle), 1);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
